// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: widths, NOP/HLT encodings and fetch FSM states.
// Also imported by the IF/ID flush path for the canonical NOP.
package fetch_pkg;

  localparam int unsigned PC_W = 16;

  localparam logic [PC_W-1:0] NOP_INSTR          = 16'h4000;
  localparam logic [3:0]      HLT_OPCODE_DEFAULT = 4'hF;
  localparam logic [PC_W-1:0] PC_STEP            = 16'h0002;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_DRAIN = 2'd1,
    FETCH_HALT  = 2'd2
  } fetch_state_e;

  // Sequential PC increment; wraps modulo 2^16 by construction.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Load-enabled address register with asynchronous active-low reset to a
// parameterised value; used for the architectural PC and the drain address.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VAL = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] d,
  output logic [PC_W-1:0] q
);

  logic [PC_W-1:0] q_r;

  // Address storage: reset value on rst_n low, captures d when load is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= RESET_VAL;
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and feeds
// {pc+2, instruction-or-NOP} to the IF/ID register every cycle.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]      HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [PC_W-1:0] imem_data,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] ins_out,
  output logic            fetch_halted
);

  fetch_state_e    state_r;
  fetch_state_e    state_next_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next_s;
  logic            pc_load_s;
  logic [PC_W-1:0] drain_addr_r;
  logic            drain_load_s;
  logic            req_s;
  logic [PC_W-1:0] addr_s;
  logic [PC_W-1:0] ins_s;
  logic            halted_s;

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst),
    .load  (pc_load_s),
    .d     (pc_next_s),
    .q     (pc_r)
  );

  // The drain address is always the PC that was outstanding when the redirect hit.
  pc_reg #(.RESET_VAL(16'h0000)) u_drain_addr (
    .clk   (clk),
    .rst_n (rst),
    .load  (drain_load_s),
    .d     (pc_r),
    .q     (drain_addr_r)
  );

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FETCH_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, next-PC and handshake/output decode.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    pc_load_s    = 1'b0;
    drain_load_s = 1'b0;
    req_s        = 1'b0;
    addr_s       = pc_r;
    ins_s        = NOP_INSTR;
    halted_s     = 1'b0;

    case (state_r)
      FETCH_RUN: begin
        req_s  = 1'b1;
        addr_s = pc_r;
        if (imem_ready && !branch_taken) begin
          ins_s = imem_data;
        end else begin
          ins_s = NOP_INSTR;
        end

        if (branch_taken) begin
          pc_load_s = 1'b1;
          pc_next_s = branch_target;
          // Memory cannot cancel the in-flight request, so wait it out.
          if (!imem_ready) begin
            drain_load_s = 1'b1;
            state_next_s = FETCH_DRAIN;
          end else begin
            state_next_s = FETCH_RUN;
          end
        end else if (imem_ready && stall) begin
          pc_load_s = 1'b0;
        end else if (imem_ready && (imem_data[15:12] == HLT_OPCODE)) begin
          state_next_s = FETCH_HALT;
        end else if (imem_ready) begin
          pc_load_s = 1'b1;
          pc_next_s = pc_inc(pc_r);
        end else begin
          pc_load_s = 1'b0;
        end
      end

      FETCH_DRAIN: begin
        req_s  = 1'b1;
        addr_s = drain_addr_r;
        ins_s  = NOP_INSTR;
        if (branch_taken) begin
          pc_load_s = 1'b1;
          pc_next_s = branch_target;
        end else begin
          pc_load_s = 1'b0;
        end
        if (imem_ready) begin
          state_next_s = FETCH_RUN;
        end else begin
          state_next_s = FETCH_DRAIN;
        end
      end

      FETCH_HALT: begin
        halted_s = 1'b1;
        // An older branch can still squash a speculatively fetched HLT.
        if (branch_taken) begin
          pc_load_s    = 1'b1;
          pc_next_s    = branch_target;
          state_next_s = FETCH_RUN;
        end else begin
          state_next_s = FETCH_HALT;
        end
      end

      default: begin
        state_next_s = FETCH_RUN;
      end
    endcase
  end

  // Reset gates the handshake combinationally so a stale ready cannot leak through.
  assign imem_req     = rst & req_s;
  assign imem_addr    = addr_s;
  assign ins_out      = rst ? ins_s : NOP_INSTR;
  assign pc_out       = pc_inc(pc_r);
  assign fetch_halted = rst & halted_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] pc_out;
  logic [15:0] ins_out;
  logic        fetch_halted;

  typedef struct packed {
    logic [7:0]  idx;
    logic        req;
    logic [15:0] addr;
    logic [15:0] ins;
    logic [15:0] pc;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   vec_idx;

  fetch_stage #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .pc_out        (pc_out),
    .ins_out       (ins_out),
    .fetch_halted  (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs just after the rising edge and queue its expected outputs.
  task automatic vec(input logic r, input logic st, input logic br, input logic [15:0] tgt,
                     input logic rdy, input logic [15:0] data,
                     input logic e_req, input logic [15:0] e_addr, input logic [15:0] e_ins,
                     input logic [15:0] e_pc, input logic e_halt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = st; branch_taken = br; branch_target = tgt;
    imem_ready = rdy; imem_data = data;
    e.idx = 8'(vec_idx); e.req = e_req; e.addr = e_addr; e.ins = e_ins;
    e.pc = e_pc; e.halted = e_halt;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued vector is checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (imem_req !== e.req) begin
        failures++;
        $display("FAIL v%0d imem_req actual=%b expected=%b", e.idx, imem_req, e.req);
      end
      if (e.req) begin
        checks++;
        if (imem_addr !== e.addr) begin
          failures++;
          $display("FAIL v%0d imem_addr actual=%h expected=%h", e.idx, imem_addr, e.addr);
        end
      end
      checks++;
      if (ins_out !== e.ins) begin
        failures++;
        $display("FAIL v%0d ins_out actual=%h expected=%h", e.idx, ins_out, e.ins);
      end
      checks++;
      if (pc_out !== e.pc) begin
        failures++;
        $display("FAIL v%0d pc_out actual=%h expected=%h", e.idx, pc_out, e.pc);
      end
      checks++;
      if (fetch_halted !== e.halted) begin
        failures++;
        $display("FAIL v%0d fetch_halted actual=%b expected=%b", e.idx, fetch_halted, e.halted);
      end
    end
  end

  initial begin
    int budget;
    checks = 0; failures = 0; vec_idx = 0;
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    imem_ready = 1'b0; imem_data = 16'h0000;

    //  rst  stl  br   target    rdy  data       req  addr      ins       pc_out    halt
    // In reset: ready is high but must be ignored.
    vec(1'b0,1'b0,1'b0,16'h0000,1'b1,16'h1234, 1'b0,16'h0000,16'h4000,16'h0002,1'b0);
    // Sequential fetch.
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h1234, 1'b1,16'h0000,16'h1234,16'h0002,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h2345, 1'b1,16'h0002,16'h2345,16'h0004,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h3456, 1'b1,16'h0004,16'h3456,16'h0006,1'b0);
    // Memory wait: address held, NOP inserted.
    vec(1'b1,1'b0,1'b0,16'h0000,1'b0,16'hDEAD, 1'b1,16'h0006,16'h4000,16'h0008,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b0,16'hDEAD, 1'b1,16'h0006,16'h4000,16'h0008,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b0,16'hDEAD, 1'b1,16'h0006,16'h4000,16'h0008,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'hABCD, 1'b1,16'h0006,16'hABCD,16'h0008,1'b0);
    // Redirect while request outstanding at pc=8 -> DRAIN.
    vec(1'b1,1'b0,1'b1,16'h0100,1'b0,16'hDEAD, 1'b1,16'h0008,16'h4000,16'h000A,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b0,16'hDEAD, 1'b1,16'h0008,16'h4000,16'h0102,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h5555, 1'b1,16'h0008,16'h4000,16'h0102,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h1111, 1'b1,16'h0100,16'h1111,16'h0102,1'b0);
    // HLT fetched, then HALT, then squashed by a branch.
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'hF000, 1'b1,16'h0102,16'hF000,16'h0104,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h7777, 1'b0,16'h0000,16'h4000,16'h0104,1'b1);
    vec(1'b1,1'b0,1'b1,16'h0040,1'b0,16'h0000, 1'b0,16'h0000,16'h4000,16'h0104,1'b1);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h2222, 1'b1,16'h0040,16'h2222,16'h0042,1'b0);
    // Stall holds PC; stall plus branch: branch wins.
    vec(1'b1,1'b1,1'b0,16'h0000,1'b1,16'h3333, 1'b1,16'h0042,16'h3333,16'h0044,1'b0);
    vec(1'b1,1'b1,1'b1,16'h0020,1'b1,16'h4444, 1'b1,16'h0042,16'h4000,16'h0044,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h4444, 1'b1,16'h0020,16'h4444,16'h0022,1'b0);
    // Wrap at 16'hFFFE.
    vec(1'b1,1'b0,1'b1,16'hFFFE,1'b1,16'h9999, 1'b1,16'h0022,16'h4000,16'h0024,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h1357, 1'b1,16'hFFFE,16'h1357,16'h0000,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0000,16'h4000,16'h0002,1'b0);
    // Stalled HLT does not halt.
    vec(1'b1,1'b1,1'b0,16'h0000,1'b1,16'hF000, 1'b1,16'h0000,16'hF000,16'h0002,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h1000, 1'b1,16'h0000,16'h1000,16'h0002,1'b0);
    // Redirect into DRAIN, second redirect during DRAIN, then reset mid-drain.
    vec(1'b1,1'b0,1'b1,16'h0200,1'b0,16'h0000, 1'b1,16'h0002,16'h4000,16'h0004,1'b0);
    vec(1'b1,1'b0,1'b1,16'h0300,1'b0,16'h0000, 1'b1,16'h0002,16'h4000,16'h0202,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0002,16'h4000,16'h0302,1'b0);
    vec(1'b0,1'b0,1'b0,16'h0000,1'b1,16'h6666, 1'b0,16'h0000,16'h4000,16'h0002,1'b0);
    vec(1'b0,1'b0,1'b0,16'h0000,1'b1,16'h6666, 1'b0,16'h0000,16'h4000,16'h0002,1'b0);
    vec(1'b1,1'b0,1'b0,16'h0000,1'b1,16'h7070, 1'b1,16'h0000,16'h7070,16'h0002,1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_queue remaining=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
